// File: rtl/cpu_trace_buffer_if.sv
// rtl/cpu_trace_buffer_if.sv - core capture bus and indexed read port of the trace buffer.
interface cpu_trace_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int IDX_W  = 4
);
  logic              cap_valid;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instruction;
  logic              regwrite;
  logic [REG_W-1:0]  wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [IDX_W-1:0]  rd_idx;
  logic [ADDR_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;
  logic              rd_regwrite;
  logic [REG_W-1:0]  rd_reg;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cap_valid, pc, instruction, regwrite, wr_reg, wr_data, rd_idx,
    input  rd_pc, rd_instr, rd_regwrite, rd_reg, rd_data
  );

  modport slave (
    input  cap_valid, pc, instruction, regwrite, wr_reg, wr_data, rd_idx,
    output rd_pc, rd_instr, rd_regwrite, rd_reg, rd_data
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - circular execution-trace capture with PC/forced trigger and post-trigger freeze.
// Optional TRACE_WB_FILTER_EN: store only register-writing cycles; triggers still see every valid cycle.
module cpu_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int POST_TRIG = 8
) (
  input  logic               clk,
  input  logic               rst,
  cpu_trace_buffer_if.slave  trc,
  input  logic               arm_i,
  input  logic               force_trig_i,
  input  logic [ADDR_W-1:0]  trig_pc_i,
  input  logic               trig_pc_on_i,
  output logic [1:0]         state_o,
  output logic [IDX_W:0]     count_o,
  output logic [IDX_W-1:0]   trig_slot_o,
  output logic               done_o
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int ENT_W = ADDR_W + DATA_W + 1 + REG_W + DATA_W;
  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   POST_W  = (IDX_W+1)'(POST_TRIG);
  localparam logic [IDX_W-1:0] POST_C  = IDX_W'(POST_TRIG);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   wptr_q, wptr_d;
  logic [IDX_W-1:0]   post_q, post_d;
  logic [IDX_W:0]     count_q, count_d;
  logic               trig_adj_q, trig_adj_d;
  logic [ENT_W-1:0]   rd_q, rd_d;
  logic               store, store_ok, trig_hit;
  logic [ENT_W-1:0]   wr_ent;
  logic [IDX_W-1:0]   rd_slot;
  logic [IDX_W:0]     ts_full;
  logic [ENT_W-1:0]   mem [DEPTH];

  assign wr_ent   = {trc.pc, trc.instruction, trc.regwrite, trc.wr_reg, trc.wr_data};
  assign trig_hit = trc.cap_valid && (force_trig_i || (trig_pc_on_i && (trc.pc == trig_pc_i)));

`ifdef TRACE_WB_FILTER_EN
  assign store_ok = trc.cap_valid && trc.regwrite;
`else
  assign store_ok = trc.cap_valid;
`endif

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    post_d     = post_q;
    trig_adj_d = trig_adj_q;
    store      = 1'b0;
    if (arm_i) begin
      state_d    = S_ARMED;
      wptr_d     = '0;
      count_d    = '0;
      post_d     = '0;
      trig_adj_d = 1'b0;
    end else if (state_q == S_ARMED || state_q == S_POST) begin
      store = store_ok;
      if (store) begin
        wptr_d = wptr_q + 1'b1;
        if (count_q != DEPTH_C) count_d = count_q + 1'b1;
      end
      // trig_adj records whether the trigger cycle itself occupies a slot
      if (state_q == S_ARMED && trig_hit) begin
        trig_adj_d = store;
        if (POST_TRIG == 0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_POST;
          post_d  = POST_C;
        end
      end else if (state_q == S_POST && store) begin
        post_d = post_q - 1'b1;
        if (post_q == IDX_W'(1)) state_d = S_DONE;
      end
    end
  end

  // count==DEPTH truncates to 0, so the oldest slot is then wptr itself
  assign rd_slot = wptr_q - count_q[IDX_W-1:0] + trc.rd_idx;

  always_comb begin
    rd_d = '0;
    if ({1'b0, trc.rd_idx} < count_q) rd_d = mem[rd_slot];
  end

  always_ff @(posedge clk) begin
    if (store) mem[wptr_q] <= wr_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      count_q    <= '0;
      post_q     <= '0;
      trig_adj_q <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      trig_adj_q <= trig_adj_d;
      rd_q       <= rd_d;
    end
  end

  assign ts_full     = count_q - POST_W - {{IDX_W{1'b0}}, trig_adj_q};
  assign trig_slot_o = (state_q == S_DONE) ? ts_full[IDX_W-1:0] : '0;
  assign state_o     = state_q;
  assign count_o     = count_q;
  assign done_o      = (state_q == S_DONE);

  assign trc.rd_data     = rd_q[DATA_W-1:0];
  assign trc.rd_reg      = rd_q[DATA_W +: REG_W];
  assign trc.rd_regwrite = rd_q[DATA_W+REG_W];
  assign trc.rd_instr    = rd_q[DATA_W+REG_W+1 +: DATA_W];
  assign trc.rd_pc       = rd_q[ENT_W-1 -: ADDR_W];
endmodule
